term1_capture: RTL

- Downstream stage of the term1 combinational decode cloud.
- Accepts a launch strobe when the upstream logic has applied a new 34-bit input vector to term1.
- Waits a programmable settle time for the multi-level gate path to resolve, then samples the 10 term1 outputs (s0..j0).
- Tags each sample with a sequence number and buffers it in a small FIFO, drained by a valid/ready consumer.

---
 rtl/term1_pkg.sv | 30 +++
 rtl/term1_cap_fifo.sv | 58 +++++
 rtl/term1_capture.sv | 107 ++++++++++
 3 files changed

// File: rtl/term1_pkg.sv
// Shared types and constants for the term1 capture stage.
package term1_pkg;

   localparam int TERM_W     = 10;
   localparam int SEQ_W_DFLT = 8;

   localparam int S0_BIT = 9;
   localparam int R0_BIT = 8;
   localparam int Q0_BIT = 7;
   localparam int P0_BIT = 6;
   localparam int O0_BIT = 5;
   localparam int N0_BIT = 4;
   localparam int M0_BIT = 3;
   localparam int L0_BIT = 2;
   localparam int K0_BIT = 1;
   localparam int J0_BIT = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      PUSH   = 2'd2
   } fsm_t;

   // Entry layout at the default tag width; the top packs the same order at its own SEQ_W.
   typedef struct packed {
      logic [TERM_W-1:0]     data;
      logic [SEQ_W_DFLT-1:0] seq;
   } cap_t;

endpackage

// File: rtl/term1_cap_fifo.sv
// Synchronous FIFO for captured term1 samples; head is zero while empty.
module term1_cap_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A write into a full FIFO is legal when the head leaves on the same edge.
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/term1_capture.sv
// Launch/settle/sample sequencer for the term1 decode outputs, feeding a tagged FIFO.
//
// state  | meaning
// IDLE   | ready for a launch; upstream may change term1 inputs
// SETTLE | counting down while the term1 gate path resolves
// PUSH   | sampling term_in into the FIFO, held while the FIFO is full
module term1_capture
   import term1_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int DEPTH  = 4,
   parameter int SEQ_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     launch_valid,
   output logic                     launch_ready,
   input  logic [TERM_W-1:0]        term_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TERM_W-1:0]        out_data,
   output logic [SEQ_W-1:0]         out_seq,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy
);

   localparam int ENT_W = TERM_W + SEQ_W;

   fsm_t              state;
   fsm_t              state_nxt;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nxt;
   logic [SEQ_W-1:0]  seq;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [ENT_W-1:0]  rd_data;

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      push         = 1'b0;
      launch_ready = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            launch_ready = 1'b1;
            busy         = 1'b0;
            if (launch_valid) begin
               cnt_nxt   = 4'(SETTLE - 1);
               state_nxt = term1_pkg::SETTLE;
            end
         end
         term1_pkg::SETTLE: begin
            if (cnt == 4'd0) begin
               state_nxt = PUSH;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         PUSH: begin
            if (!full || pop) begin
               push      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         seq   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (push) begin
            seq <= seq + SEQ_W'(1);
         end
      end
   end

   term1_cap_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data ({term_in, seq}),
      .pop     (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign out_data = rd_data[ENT_W-1:SEQ_W];
   assign out_seq  = rd_data[SEQ_W-1:0];

endmodule
